// File: rtl/sha256_round_ctrl_if.sv
// Block-transfer handshake between the padding/block buffer and the
// SHA-256 round controller. The buffer holds the 512-bit block; this
// interface carries only the valid/last/ready qualifiers.
interface sha256_round_ctrl_if;
   logic blk_valid;
   logic blk_last;
   logic blk_ready;

   modport master (
      output blk_valid,
      output blk_last,
      input  blk_ready
   );

   modport slave (
      input  blk_valid,
      input  blk_last,
      output blk_ready
   );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer. Accepts blocks over a valid/ready handshake
// and drives init, round enable (ready), round_idx, w_sel, digest_update,
// wv_reload and done for the compression datapath.
// Optional feature: define SHA256_CTRL_ABORT_EN to add an abort input that
// returns the controller to IDLE from any state.
module sha256_round_ctrl #(
   parameter int NUM_ROUNDS = 64,
   parameter int BLK_CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
`ifdef SHA256_CTRL_ABORT_EN
   input  logic                          abort,
`endif
   sha256_round_ctrl_if.slave            blk,
   output logic                          init,
   output logic                          ready,
   output logic [$clog2(NUM_ROUNDS)-1:0] round_idx,
   output logic                          w_sel,
   output logic                          digest_update,
   output logic                          wv_reload,
   output logic                          done,
   output logic                          busy,
   output logic [BLK_CNT_W-1:0]          blk_cnt
);

   localparam int IDX_W = $clog2(NUM_ROUNDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ROUND,
      S_UPDATE,
      S_RELOAD,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IDX_W-1:0]     cnt;
   logic [IDX_W-1:0]     cnt_nxt;
   logic [BLK_CNT_W-1:0] blk_cnt_nxt;
   logic                 last_flag;
   logic                 last_nxt;
   logic                 accept;
   logic                 abort_i;

   // Block counter never wraps: a very long message pins at all-ones.
   function automatic logic [BLK_CNT_W-1:0] sat_inc(input logic [BLK_CNT_W-1:0] v);
      return (&v) ? v : v + BLK_CNT_W'(1);
   endfunction

`ifdef SHA256_CTRL_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   // blk_ready depends only on registered state (and abort), never on blk_valid.
   assign accept = blk.blk_valid & blk.blk_ready;

   // State, round counter, block counter and last-block flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         blk_cnt   <= '0;
         last_flag <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         blk_cnt   <= blk_cnt_nxt;
         last_flag <= last_nxt;
      end
   end

   // Next-state and counter update logic; abort overrides every transition.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      blk_cnt_nxt = blk_cnt;
      last_nxt    = last_flag;
      case (state)
         S_IDLE: begin
            if (accept) begin
               last_nxt    = blk.blk_last;
               blk_cnt_nxt = '0;
               state_nxt   = S_INIT;
            end
         end
         S_INIT: begin
            cnt_nxt   = '0;
            state_nxt = S_ROUND;
         end
         S_ROUND: begin
            if (cnt == LAST_IDX) begin
               cnt_nxt     = '0;
               blk_cnt_nxt = sat_inc(blk_cnt);
               state_nxt   = S_UPDATE;
            end else begin
               cnt_nxt = cnt + IDX_W'(1);
            end
         end
         S_UPDATE: begin
            state_nxt = last_flag ? S_DONE : S_RELOAD;
         end
         S_RELOAD: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A block taken here always continues the current message.
            if (accept) begin
               last_nxt  = blk.blk_last;
               cnt_nxt   = '0;
               state_nxt = S_ROUND;
            end
         end
         S_DONE: begin
            // A block taken here starts a new message.
            if (accept) begin
               last_nxt    = blk.blk_last;
               blk_cnt_nxt = '0;
               state_nxt   = S_INIT;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (abort_i) begin
         state_nxt   = S_IDLE;
         cnt_nxt     = '0;
         blk_cnt_nxt = '0;
         last_nxt    = 1'b0;
      end
   end

   // Output decode from registered state and round counter only.
   always_comb begin
      blk.blk_ready = 1'b0;
      init          = 1'b0;
      ready         = 1'b0;
      w_sel         = 1'b0;
      digest_update = 1'b0;
      wv_reload     = 1'b0;
      done          = 1'b0;
      busy          = 1'b1;
      round_idx     = cnt;
      case (state)
         S_IDLE: begin
            blk.blk_ready = 1'b1;
            busy          = 1'b0;
         end
         S_INIT: begin
            init = 1'b1;
         end
         S_ROUND: begin
            ready = 1'b1;
            w_sel = (32'(cnt) >= 32'd16);
         end
         S_UPDATE: begin
            digest_update = 1'b1;
         end
         S_RELOAD: begin
            wv_reload = 1'b1;
         end
         S_WAIT: begin
            blk.blk_ready = 1'b1;
         end
         S_DONE: begin
            blk.blk_ready = 1'b1;
            done          = 1'b1;
            busy          = 1'b0;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
      if (abort_i) begin
         blk.blk_ready = 1'b0;
      end
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: single block, three-block message,
// ignored valid during rounds, restart from DONE, mid-message reset and
// (with SHA256_CTRL_ABORT_EN) abort in WAIT.
module tb_sha256_round_ctrl;

   logic        clk;
   logic        reset;
`ifdef SHA256_CTRL_ABORT_EN
   logic        abort;
`endif
   logic        init;
   logic        ready;
   logic [5:0]  round_idx;
   logic        w_sel;
   logic        digest_update;
   logic        wv_reload;
   logic        done;
   logic        busy;
   logic [15:0] blk_cnt;

   int n_chk = 0;
   int n_err = 0;
   int init_seen = 0;
   int reload_seen = 0;

   sha256_round_ctrl_if bif ();

   sha256_round_ctrl #(
      .NUM_ROUNDS (64),
      .BLK_CNT_W  (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
`ifdef SHA256_CTRL_ABORT_EN
      .abort         (abort),
`endif
      .blk           (bif),
      .init          (init),
      .ready         (ready),
      .round_idx     (round_idx),
      .w_sel         (w_sel),
      .digest_update (digest_update),
      .wv_reload     (wv_reload),
      .done          (done),
      .busy          (busy),
      .blk_cnt       (blk_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count strobe pulses mid-cycle.
   always @(negedge clk) begin
      if (init) init_seen++;
      if (wv_reload) reload_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Walk through 64 rounds; optionally pulse blk_valid during round pulse_at.
   task automatic do_rounds(input int pulse_at);
      for (int i = 0; i < 64; i++) begin
         step();
         if (pulse_at >= 0 && i == pulse_at + 1) bif.blk_valid = 1'b0;
         chk("ready", 32'(ready), 32'd1);
         chk("round_idx", 32'(round_idx), 32'(i));
         chk("w_sel", 32'(w_sel), (i >= 16) ? 32'd1 : 32'd0);
         if (i == 0) chk("init_in_round", 32'(init), 32'd0);
         if (pulse_at >= 0 && i == pulse_at) begin
            chk("blk_ready_round", 32'(bif.blk_ready), 32'd0);
            bif.blk_valid = 1'b1;
         end
      end
   endtask

   initial begin
      int init_base;
      int rel_base;
      reset = 1'b1;
      bif.blk_valid = 1'b0;
      bif.blk_last  = 1'b0;
`ifdef SHA256_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      #12;
      // Reset state
      chk("rst_blk_ready", 32'(bif.blk_ready), 32'd1);
      chk("rst_init", 32'(init), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
      chk("rst_round_idx", 32'(round_idx), 32'd0);
      reset = 1'b0;

      // 1: single block
      bif.blk_valid = 1'b1;
      bif.blk_last  = 1'b1;
      step();
      chk("t1_init", 32'(init), 32'd1);
      chk("t1_blk_ready_init", 32'(bif.blk_ready), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      bif.blk_valid = 1'b0;
      do_rounds(-1);
      step();
      chk("t1_upd", 32'(digest_update), 32'd1);
      chk("t1_upd_ready", 32'(ready), 32'd0);
      chk("t1_upd_cnt", 32'(blk_cnt), 32'd1);
      step();
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_done_blk_ready", 32'(bif.blk_ready), 32'd1);
      chk("t1_done_busy", 32'(busy), 32'd0);
      chk("t1_done_cnt", 32'(blk_cnt), 32'd1);
      step();
      chk("t1_done_hold", 32'(done), 32'd1);

      // 4 + 3: new message from DONE, valid pulsed during rounds
      bif.blk_valid = 1'b1;
      bif.blk_last  = 1'b1;
      step();
      chk("t4_done_fall", 32'(done), 32'd0);
      chk("t4_init", 32'(init), 32'd1);
      chk("t4_cnt_clr", 32'(blk_cnt), 32'd0);
      bif.blk_valid = 1'b0;
      do_rounds(5);
      step();
      chk("t3_upd", 32'(digest_update), 32'd1);
      chk("t3_cnt", 32'(blk_cnt), 32'd1);
      step();
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_cnt", 32'(blk_cnt), 32'd1);

      // 2: three-block message, valid held high
      init_base = init_seen;
      rel_base  = reload_seen;
      bif.blk_valid = 1'b1;
      bif.blk_last  = 1'b0;
      step();
      chk("t2_init", 32'(init), 32'd1);
      for (int b = 0; b < 3; b++) begin
         do_rounds(-1);
         step();
         chk("t2_upd", 32'(digest_update), 32'd1);
         chk("t2_upd_cnt", 32'(blk_cnt), 32'(b + 1));
         chk("t2_upd_blk_ready", 32'(bif.blk_ready), 32'd0);
         if (b < 2) begin
            step();
            chk("t2_reload", 32'(wv_reload), 32'd1);
            chk("t2_reload_upd", 32'(digest_update), 32'd0);
            chk("t2_reload_blk_ready", 32'(bif.blk_ready), 32'd0);
            step();
            chk("t2_wait_blk_ready", 32'(bif.blk_ready), 32'd1);
            chk("t2_wait_busy", 32'(busy), 32'd1);
            chk("t2_wait_done", 32'(done), 32'd0);
            if (b == 1) bif.blk_last = 1'b1;
         end else begin
            bif.blk_valid = 1'b0;
         end
      end
      step();
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_cnt", 32'(blk_cnt), 32'd3);
      chk("t2_init_pulses", 32'(init_seen - init_base), 32'd1);
      chk("t2_reload_pulses", 32'(reload_seen - rel_base), 32'd2);

      // 5: reset at round_idx 30 of block 2
      bif.blk_valid = 1'b1;
      bif.blk_last  = 1'b0;
      step();
      bif.blk_valid = 1'b0;
      do_rounds(-1);
      step();
      step();
      step();
      chk("t5_wait", 32'(bif.blk_ready), 32'd1);
      bif.blk_valid = 1'b1;
      bif.blk_last  = 1'b1;
      for (int i = 0; i <= 30; i++) begin
         step();
         chk("t5_idx", 32'(round_idx), 32'(i));
      end
      chk("t5_cnt_pre", 32'(blk_cnt), 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_blk_ready", 32'(bif.blk_ready), 32'd1);
      chk("t5_ready", 32'(ready), 32'd0);
      chk("t5_idx_rst", 32'(round_idx), 32'd0);
      chk("t5_w_sel", 32'(w_sel), 32'd0);
      chk("t5_cnt", 32'(blk_cnt), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      bif.blk_valid = 1'b0;
      #1;
      reset = 1'b0;
      step();
      chk("t5_idle_blk_ready", 32'(bif.blk_ready), 32'd1);
      chk("t5_idle_busy", 32'(busy), 32'd0);
      chk("t5_idle_init", 32'(init), 32'd0);

`ifdef SHA256_CTRL_ABORT_EN
      // 6: abort together with valid in WAIT
      bif.blk_valid = 1'b1;
      bif.blk_last  = 1'b0;
      step();
      bif.blk_valid = 1'b0;
      do_rounds(-1);
      step();
      step();
      step();
      chk("t6_wait_cnt", 32'(blk_cnt), 32'd1);
      abort = 1'b1;
      bif.blk_valid = 1'b1;
      #1;
      chk("t6_blk_ready_abort", 32'(bif.blk_ready), 32'd0);
      step();
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_ready", 32'(ready), 32'd0);
      chk("t6_cnt", 32'(blk_cnt), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      abort = 1'b0;
      bif.blk_valid = 1'b0;
      #1;
      chk("t6_idle_blk_ready", 32'(bif.blk_ready), 32'd1);
      step();
      chk("t6_idle_init", 32'(init), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
